// File: rtl/vx_commit_arbiter_pkg.sv
// Shared definitions for the commit arbiter: buffer depth and arbiter FSM states.
package vx_commit_arbiter_pkg;

    // Two entries are enough to cover the one-cycle registered-full turnaround
    // and keep one commit per cycle flowing.
    localparam int COMMIT_ARB_BUF_DEPTH = 2;

    // IDLE: round-robin pick among valid units.
    // LOCKED: the unit that started a multi-beat packet owns the port until eop.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vx_commit_elastic_buf.sv
// Two-entry FIFO that registers the arbiter output. The producer must only
// push while count < COMMIT_ARB_BUF_DEPTH. The arbiter derives its ready from
// the registered count, so no ready path runs back from the consumer.
module vx_commit_elastic_buf
    import vx_commit_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [COMMIT_ARB_BUF_DEPTH];
    // Single-bit pointers: the depth is fixed at two entries.
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    assign push      = in_valid;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

    // Storage, pointers and occupancy; reset discards all contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < COMMIT_ARB_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (!push && pop) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Round-robin commit arbiter with packet locking. Multi-beat packets (sop..eop)
// from one execute unit are never interleaved with other units' beats.
// Handshake: a beat moves on unit i when req_valid[i] && req_ready[i]. The
// output moves when out_valid && out_ready. A unit is never ready unless it is
// valid, and at most one req_ready bit is high.
module vx_commit_arbiter
    import vx_commit_arbiter_pkg::*;
#(
    parameter int NUM_REQS   = 4,
    parameter int DATAW      = 64,
    parameter int PERF_CTR_W = 44
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*DATAW-1:0]     req_data,
    input  logic [NUM_REQS-1:0]           req_sop,
    input  logic [NUM_REQS-1:0]           req_eop,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          out_valid,
    output logic [DATAW-1:0]              out_data,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [$clog2(NUM_REQS)-1:0]   out_sel,
    input  logic                          out_ready,
    output logic [PERF_CTR_W-1:0]         perf_stalls,
    output arb_state_t                    dbg_state
);

    localparam int SELW = $clog2(NUM_REQS);
    localparam int BUFW = DATAW + SELW + 2;

    arb_state_t            state, state_n;
    logic [SELW-1:0]       rr_ptr, rr_ptr_n;
    logic [SELW-1:0]       lock_idx, lock_idx_n;
    logic [SELW-1:0]       rr_idx;
    logic                  rr_found;
    logic [SELW-1:0]       cand;
    logic [SELW-1:0]       grant_idx;
    logic                  grant_valid;
    logic                  space;
    logic                  accept;
    logic                  acc_eop;
    logic [BUFW-1:0]       push_data;
    logic [BUFW-1:0]       head_data;
    logic [1:0]            buf_count;
    logic [PERF_CTR_W-1:0] stall_cnt;

    // Space is taken from the registered count, never from out_ready.
    assign space   = (buf_count < 2'(COMMIT_ARB_BUF_DEPTH));
    assign accept  = grant_valid && space && reset;
    assign acc_eop = req_eop[grant_idx];

    // Round-robin pick: first valid unit after rr_ptr, wrapping.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            cand = SELW'((int'(rr_ptr) + k) % NUM_REQS);
            if (!rr_found && req_valid[cand]) begin
                rr_idx   = cand;
                rr_found = 1'b1;
            end
        end
    end

    // Grant: the lock owner while LOCKED (nobody if it is not valid), else the RR pick.
    always_comb begin
        grant_idx   = rr_idx;
        grant_valid = rr_found;
        if (state == ARB_LOCKED) begin
            grant_idx   = lock_idx;
            grant_valid = req_valid[lock_idx];
        end
    end

    // One-hot ready toward the granted unit while the buffer has room.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Arbiter state register; order and lock only change on an accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            rr_ptr   <= SELW'(NUM_REQS - 1);
            lock_idx <= '0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            lock_idx <= lock_idx_n;
        end
    end

    // Next-state: lock on a non-final beat taken in IDLE, unlock on eop.
    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        lock_idx_n = lock_idx;
        case (state)
            ARB_IDLE: begin
                if (accept) begin
                    rr_ptr_n = grant_idx;
                    if (!acc_eop) begin
                        lock_idx_n = grant_idx;
                        state_n    = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                if (accept && acc_eop) begin
                    state_n = ARB_IDLE;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // Stall counter: a unit is waiting but nothing moved this cycle; saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((|req_valid) && !accept && (stall_cnt != {PERF_CTR_W{1'b1}})) begin
            stall_cnt <= stall_cnt + PERF_CTR_W'(1);
        end
    end

    assign push_data = {grant_idx, req_sop[grant_idx], req_eop[grant_idx],
                        req_data[int'(grant_idx)*DATAW +: DATAW]};

    vx_commit_elastic_buf #(
        .WIDTH (BUFW)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_data   (push_data),
        .out_valid (out_valid),
        .out_data  (head_data),
        .out_ready (out_ready),
        .count     (buf_count)
    );

    assign {out_sel, out_sop, out_eop, out_data} = head_data;
    assign perf_stalls = stall_cnt;
    assign dbg_state   = state;

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Bench for vx_commit_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a packet-level reference model.
module tb_vx_commit_arbiter;
    import vx_commit_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int PW = 44;
    localparam int SW = 2;
    localparam int BW = DW + SW + 2;
    localparam logic [PW-1:0] SAT = {PW{1'b1}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_sop = '0;
    logic [N-1:0]    req_eop = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_sop;
    logic            out_eop;
    logic [SW-1:0]   out_sel;
    logic            out_ready = 1'b0;
    logic [PW-1:0]   perf_stalls;
    arb_state_t      dbg_state;

    vx_commit_arbiter #(.NUM_REQS(N), .DATAW(DW), .PERF_CTR_W(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_sop     (req_sop),
        .req_eop     (req_eop),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_sel     (out_sel),
        .out_ready   (out_ready),
        .perf_stalls (perf_stalls),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // Reference state: last unit served, packet owner (-1 = none),
    // committed-but-not-drained beats, stall count, beats taken per unit packet.
    logic [BW-1:0] exp_q[$];
    int            m_last;
    int            m_owner;
    logic [PW-1:0] m_stalls;
    int            unit_beat[N];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last   = N - 1;
        m_owner  = -1;
        m_stalls = '0;
        for (int i = 0; i < N; i++) unit_beat[i] = 0;
    endtask

    // Compare the DUT with the model for the current cycle, then advance the
    // model across the coming clock edge.
    task automatic eval_cycle();
        int           g;
        logic [N-1:0] exp_rdy;
        logic         acc;
        logic         pop;
        g = -1;
        if (m_owner >= 0) begin
            if (req_valid[m_owner]) g = m_owner;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0 && exp_q.size() < 2) exp_rdy[g] = 1'b1;
        acc = (exp_rdy != '0);
        pop = (exp_q.size() != 0) && out_ready;

        check("req_ready", 128'(req_ready), 128'(exp_rdy));
        check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check("out_beat", 128'({out_sel, out_sop, out_eop, out_data}), 128'(exp_q[0]));
        check("perf_stalls", 128'(perf_stalls), 128'(m_stalls));
        check("state", 128'(dbg_state), 128'(m_owner >= 0 ? ARB_LOCKED : ARB_IDLE));

        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back({SW'(g), req_sop[g], req_eop[g], req_data[g*DW +: DW]});
            m_last = g;
            if (req_eop[g]) begin
                m_owner      = -1;
                unit_beat[g] = 0;
            end else begin
                m_owner      = g;
                unit_beat[g] = unit_beat[g] + 1;
            end
        end else if (|req_valid && m_stalls != SAT) begin
            m_stalls = m_stalls + PW'(1);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge: drive one cycle of inputs, check at the
    // falling edge, return just after the next rising edge.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] e, input logic ordy);
        req_valid = v;
        req_eop   = e;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            req_sop[i]             = (unit_beat[i] == 0);
            req_data[i*DW +: DW]   = {$urandom, $urandom};
        end
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [PW-1:0] s0;

    initial begin
        model_reset();
        req_valid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_out_fields", 128'({out_sel, out_sop, out_eop, out_data}), 128'(0));
        check("rst_perf", 128'(perf_stalls), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // All units valid, single-beat packets: served 0,1,2,3,0.
        repeat (5) step(4'b1111, 4'b1111, 1'b1);

        // Unit 1 three-beat packet amid other valids, then unit 2.
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b1111, 4'b0010, 1'b1);
        step(4'b1111, 4'b1111, 1'b1);

        // Locked unit 1 drops valid for two cycles mid-packet.
        step(4'b0010, 4'b0000, 1'b1);
        s0 = perf_stalls;
        step(4'b0101, 4'b0000, 1'b1);
        step(4'b0101, 4'b0000, 1'b1);
        check("drop_stall_delta", 128'(perf_stalls - s0), 128'(2));
        step(4'b0111, 4'b0010, 1'b1);

        // Backpressure: out_ready low for five cycles with unit 0 valid.
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        s0 = perf_stalls;
        repeat (5) step(4'b0001, 4'b0001, 1'b0);
        check("bp_stall_delta", 128'(perf_stalls - s0), 128'(3));
        check("bp_ready_low", 128'(req_ready), 128'(0));
        repeat (3) step(4'b0000, 4'b0000, 1'b1);

        // Reset asserted mid-packet with the buffer full.
        repeat (3) step(4'b0011, 4'b0000, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_req_ready", 128'(req_ready), 128'(0));
        check("midrst_perf", 128'(perf_stalls), 128'(0));
        check("midrst_state", 128'(dbg_state), 128'(ARB_IDLE));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(4'b1111, 4'b1111, 1'b1);
        check("post_rst_first", 128'(out_sel), 128'(0));

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] v;
            logic [N-1:0] e;
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 99) < 70);
                e[i] = ($urandom_range(0, 99) < 40);
            end
            step(v, e, ($urandom_range(0, 99) < 75));
        end

        // Saturation: fill the buffer, preload the counter, hold the stall.
        repeat (3) step(4'b1111, 4'b1111, 1'b0);
        force dut.stall_cnt = SAT - PW'(2);
        #1;
        release dut.stall_cnt;
        m_stalls = SAT - PW'(2);
        repeat (5) step(4'b1111, 4'b1111, 1'b0);
        check("sat_hold", 128'(perf_stalls), 128'(SAT));
        repeat (3) step(4'b0000, 4'b0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
